// File: rtl/fft_data_input_pp_if.sv
// Sample write port, trigger/status and AXI-Stream master signals of the
// ping-pong FFT input buffer, bundled as one interface.
interface fft_data_input_pp_if #(
    parameter int NFFT       = 3,
    parameter int DATA_WIDTH = 32
);
    localparam int ELEMENTS_ADDR_SIZE = $clog2(2 * (2 ** NFFT));

    logic [ELEMENTS_ADDR_SIZE-1:0] wAddr;
    logic [DATA_WIDTH-1:0]         wData;
    logic                          wEn;
    logic                          tready;
    logic                          tvalid;
    logic                          tlast;
    logic [2*DATA_WIDTH-1:0]       tdata;
    logic                          trig;
    logic                          streaming;
    logic                          wBank;
    logic                          trigDropped;

    // Software / FFT-core side: drives writes, trigger and ready.
    modport master (
        output wAddr, wData, wEn, tready, trig,
        input  tvalid, tlast, tdata, streaming, wBank, trigDropped
    );

    // Buffer side.
    modport slave (
        input  wAddr, wData, wEn, tready, trig,
        output tvalid, tlast, tdata, streaming, wBank, trigDropped
    );
endinterface

// File: rtl/fft_data_input_pp.sv
// Ping-pong FFT input frame buffer. Software writes one bank of complex
// samples while the other bank is streamed out as a single AXIS packet.
// Build option: define FFT_DATA_INPUT_BITREV_EN to stream samples in
// bit-reversed index order (timing is identical in both builds).
module fft_data_input_pp #(
    parameter int NFFT       = 3,
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               resetn,
    fft_data_input_pp_if.slave bus
);
    localparam int POINT_SIZE         = 2 ** NFFT;
    localparam int N_ELEMENTS         = 2 * POINT_SIZE;
    localparam int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS);
    localparam logic [NFFT-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;

    // Two banks, RE and IM kept apart; address is {bank, sample}.
    logic [DATA_WIDTH-1:0] mem_re [0:2*POINT_SIZE-1];
    logic [DATA_WIDTH-1:0] mem_im [0:2*POINT_SIZE-1];

    state_t state_q, state_d;
    logic   wbank_q;
    logic   trig_drop_q;

    // Read-issue stage (p0) and RAM output stage (p1).
    logic [NFFT-1:0]       rd_idx_p0;
    logic                  rd_done_p0;
    logic [NFFT-1:0]       rd_addr_p0;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rd_re_p1;
    logic [DATA_WIDTH-1:0] rd_im_p1;

    // Two-entry output skid so a stall never loses the in-flight read.
    logic [2*DATA_WIDTH-1:0] skid_data_q [0:1];
    logic [1:0]              skid_cnt_q;
    logic                    skid_wr_q;
    logic                    skid_rd_q;
    logic [NFFT-1:0]         out_idx_q;

    logic       accept, drop, hs, last_beat, frame_end, tvalid;
    logic [2:0] occ;
    logic [NFFT:0] wr_sel;

`ifdef FFT_DATA_INPUT_BITREV_EN
    function automatic logic [NFFT-1:0] bitrev(input logic [NFFT-1:0] v);
        logic [NFFT-1:0] r;
        r = '0;
        for (int i = 0; i < NFFT; i++) r[i] = v[NFFT-1-i];
        return r;
    endfunction

    assign rd_addr_p0 = bitrev(rd_idx_p0);
`else
    assign rd_addr_p0 = rd_idx_p0;
`endif

    assign tvalid    = (skid_cnt_q != 2'd0);
    assign hs        = tvalid && bus.tready;
    assign last_beat = (out_idx_q == LAST_IDX);
    assign frame_end = hs && last_beat;
    assign wr_sel    = {wbank_q, bus.wAddr[ELEMENTS_ADDR_SIZE-1:1]};

    // Next state, trigger accept/drop and read-issue decision.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        vld_p0  = 1'b0;
        // Entries held or in flight after this edge's pop.
        occ = 3'(skid_cnt_q) + 3'(vld_p1) - 3'(hs);
        if (bus.trig) begin
            if (state_q == IDLE) accept = 1'b1;
            else                 drop   = 1'b1;
        end
        if (state_q != IDLE && !rd_done_p0 && occ < 3'd2) vld_p0 = 1'b1;
        case (state_q)
            IDLE:     if (accept) state_d = PREFETCH;
            PREFETCH: state_d = STREAM;
            STREAM:   if (frame_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control state: FSM, bank select, read index, skid pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wbank_q     <= 1'b0;
            trig_drop_q <= 1'b0;
            rd_idx_p0   <= '0;
            rd_done_p0  <= 1'b0;
            vld_p1      <= 1'b0;
            skid_cnt_q  <= 2'd0;
            skid_wr_q   <= 1'b0;
            skid_rd_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            trig_drop_q <= drop;
            vld_p1      <= vld_p0;
            if (accept) wbank_q <= ~wbank_q;
            if (frame_end) begin
                rd_idx_p0  <= '0;
                rd_done_p0 <= 1'b0;
            end else if (vld_p0) begin
                if (rd_idx_p0 == LAST_IDX) rd_done_p0 <= 1'b1;
                else                       rd_idx_p0  <= rd_idx_p0 + 1'b1;
            end
            skid_cnt_q <= skid_cnt_q + 2'(vld_p1) - 2'(hs);
            if (vld_p1) skid_wr_q <= ~skid_wr_q;
            if (hs)     skid_rd_q <= ~skid_rd_q;
            if (frame_end)  out_idx_q <= '0;
            else if (hs)    out_idx_q <= out_idx_q + 1'b1;
        end
    end

    // Sample RAMs: writes to the fill bank, registered reads from the other.
    always_ff @(posedge clk) begin
        if (bus.wEn) begin
            if (bus.wAddr[0]) mem_im[wr_sel] <= bus.wData;
            else              mem_re[wr_sel] <= bus.wData;
        end
        // p0 -> p1: registered read of the streaming bank
        if (vld_p0) begin
            rd_re_p1 <= mem_re[{~wbank_q, rd_addr_p0}];
            rd_im_p1 <= mem_im[{~wbank_q, rd_addr_p0}];
        end
    end

    // p1 -> skid: capture each returned sample into the output skid.
    always_ff @(posedge clk) begin
        if (vld_p1) skid_data_q[skid_wr_q] <= {rd_im_p1, rd_re_p1};
    end

    assign bus.tvalid      = tvalid;
    assign bus.tlast       = tvalid && last_beat;
    assign bus.tdata       = tvalid ? skid_data_q[skid_rd_q] : '0;
    assign bus.streaming   = (state_q != IDLE);
    assign bus.wBank       = wbank_q;
    assign bus.trigDropped = trig_drop_q;
endmodule

// File: tb/tb_fft_data_input_pp.sv
// Directed bench for the ping-pong FFT input buffer: table of frames with
// different ready patterns, plus overlapped-write, dropped-trigger and
// mid-frame reset sequences.
module tb_fft_data_input_pp;
    localparam int NFFT = 3;
    localparam int DW   = 32;
    localparam int P    = 2 ** NFFT;

    typedef struct {
        logic [7:0]  tready_pat;
        logic [31:0] re_base;
        logic [31:0] im_base;
        bit          same_edge_wr;
        int          exp_beats;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    logic exp_bank;
    vec_t vecs [4];

    fft_data_input_pp_if #(.NFFT(NFFT), .DATA_WIDTH(DW)) bus ();

    fft_data_input_pp #(.NFFT(NFFT), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_idx(input int k);
`ifdef FFT_DATA_INPUT_BITREV_EN
        int r = 0;
        for (int i = 0; i < NFFT; i++) if (k[i]) r |= (1 << (NFFT - 1 - i));
        return r;
`else
        return k;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        bus.wAddr = 4'(a);
        bus.wData = d;
        bus.wEn   = 1'b1;
        @(posedge clk); #1;
        bus.wEn   = 1'b0;
    endtask

    // Fill the current write bank; optionally corrupt RE of the last sample.
    task automatic write_frame(input logic [31:0] re_b, input logic [31:0] im_b, input bit corrupt7);
        for (int k = 0; k < P; k++) begin
            if (corrupt7 && k == P - 1) write_word(2 * k, ~(re_b + 32'(k)));
            else                        write_word(2 * k, re_b + 32'(k));
            write_word(2 * k + 1, im_b + 32'(k));
        end
    endtask

    // Pulse trig (optionally with a same-edge write of RE[P-1]) and check start latency.
    task automatic trig_start(input bit same_wr, input logic [31:0] re7);
        check("wbank_pre", 64'(bus.wBank), 64'(exp_bank));
        bus.trig = 1'b1;
        if (same_wr) begin
            bus.wAddr = 4'(2 * (P - 1));
            bus.wData = re7;
            bus.wEn   = 1'b1;
        end
        @(posedge clk); #1;
        bus.trig = 1'b0;
        bus.wEn  = 1'b0;
        exp_bank = ~exp_bank;
        check("streaming_rise", 64'(bus.streaming), 64'd1);
        check("wbank_toggle", 64'(bus.wBank), 64'(exp_bank));
        check("tvalid_n0", 64'(bus.tvalid), 64'd0);
        @(posedge clk); #1;
        check("tvalid_n1", 64'(bus.tvalid), 64'd0);
        @(posedge clk); #1;
        check("tvalid_n2", 64'(bus.tvalid), 64'd1);
    endtask

    // Drain one frame under a cyclic ready pattern, checking order, tlast and stall hold.
    task automatic collect(input logic [7:0] pat, input logic [31:0] re_b, input logic [31:0] im_b,
                           input int exp_beats);
        int   beats = 0;
        int   cyc = 0;
        bit   stalled = 0;
        logic [63:0] held = '0;
        int   s;
        while (beats < P && cyc < 200) begin
            bus.tready = pat[cyc % 8];
            check("tvalid_up", 64'(bus.tvalid), 64'd1);
            check("tlast", 64'(bus.tlast), 64'(beats == P - 1));
            if (stalled) check("stall_hold", bus.tdata, held);
            if (bus.tvalid && bus.tready) begin
                s = exp_idx(beats);
                check("tdata", bus.tdata, {im_b + 32'(s), re_b + 32'(s)});
                beats++;
                stalled = 0;
            end else begin
                held    = bus.tdata;
                stalled = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("beats", 64'(beats), 64'(exp_beats));
        check("streaming_fall", 64'(bus.streaming), 64'd0);
        check("tvalid_after", 64'(bus.tvalid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 32'h0000_0000, 32'h0000_0100, 1'b0, P};
        vecs[1] = '{8'h99, 32'h0000_0000, 32'h0000_0100, 1'b0, P};
        vecs[2] = '{8'h96, 32'hA5A5_0000, 32'h5A5A_0000, 1'b1, P};
        vecs[3] = '{8'h01, 32'hFFFF_FFF8, 32'h8000_0000, 1'b0, P};

        resetn     = 1'b0;
        bus.wAddr  = '0;
        bus.wData  = '0;
        bus.wEn    = 1'b0;
        bus.tready = 1'b1;
        bus.trig   = 1'b0;
        exp_bank   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(bus.tvalid), 64'd0);
        check("rst_tlast", 64'(bus.tlast), 64'd0);
        check("rst_tdata", bus.tdata, 64'd0);
        check("rst_streaming", 64'(bus.streaming), 64'd0);
        check("rst_wbank", 64'(bus.wBank), 64'd0);
        check("rst_trigdrop", 64'(bus.trigDropped), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            write_frame(vecs[v].re_base, vecs[v].im_base, vecs[v].same_edge_wr);
            trig_start(vecs[v].same_edge_wr, vecs[v].re_base + 32'(P - 1));
            collect(vecs[v].tready_pat, vecs[v].re_base, vecs[v].im_base, vecs[v].exp_beats);
            @(posedge clk); #1;
        end

        // Overlapped write, dropped trigger, back-to-back frame.
        bus.tready = 1'b0;
        write_frame(32'h0000_0000, 32'h0000_0100, 1'b0);
        trig_start(1'b0, 32'h0);
        write_frame(32'h0000_0200, 32'h0000_0300, 1'b0);
        check("ovl_hold_valid", 64'(bus.tvalid), 64'd1);
        check("ovl_hold_data", bus.tdata, {32'h0000_0100 + 32'(exp_idx(0)), 32'(exp_idx(0))});
        bus.trig = 1'b1;
        @(posedge clk); #1;
        bus.trig = 1'b0;
        check("drop_pulse", 64'(bus.trigDropped), 64'd1);
        check("drop_wbank", 64'(bus.wBank), 64'(exp_bank));
        check("drop_streaming", 64'(bus.streaming), 64'd1);
        @(posedge clk); #1;
        check("drop_pulse_end", 64'(bus.trigDropped), 64'd0);
        collect(8'hFF, 32'h0000_0000, 32'h0000_0100, P);
        trig_start(1'b0, 32'h0);
        collect(8'hFF, 32'h0000_0200, 32'h0000_0300, P);

        // Reset during beat 3.
        @(posedge clk); #1;
        write_frame(32'h0000_0040, 32'h0000_0140, 1'b0);
        trig_start(1'b0, 32'h0);
        bus.tready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("beat3_data", bus.tdata, {32'h0000_0140 + 32'(exp_idx(3)), 32'h0000_0040 + 32'(exp_idx(3))});
        #3;
        resetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(bus.tvalid), 64'd0);
        check("arst_streaming", 64'(bus.streaming), 64'd0);
        check("arst_wbank", 64'(bus.wBank), 64'd0);
        check("arst_tlast", 64'(bus.tlast), 64'd0);
        exp_bank = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tvalid", 64'(bus.tvalid), 64'd0);
        write_frame(32'h0000_0070, 32'h0000_0170, 1'b0);
        trig_start(1'b0, 32'h0);
        collect(8'hFF, 32'h0000_0070, 32'h0000_0170, P);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
